alu_ctrl_md: RTL

Parametrised ALU control unit for the RISC-V core. It keeps the single-cycle decode of `alu_op`/`func3`/`func7` into `op`/`sel` for the base integer ALU. It adds a sequential multiply/divide engine for RV32M/RV64M (`func7[0]`=1 on R-type) with a stall/done handshake toward the pipeline. It sits in the execute stage between the main decoder and the ALU/writeback mux.

---
 rtl/alu_ctrl_md.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: execute-stage ALU control with a sequential RV32M/RV64M engine.
//
// Base ALU decode of alu_op/func3/func7_5 into op/sel is combinational and
// does not depend on engine state. M-ops (valid R-type with func7_0 set) go to
// a shift-add multiplier / restoring divider that finishes one bit per cycle.
// Divide by zero and signed divide overflow complete on a fast path.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i, flush_i  instruction valid in execute, pipeline flush
//   alu_op            00 R-type, 01 I-type, 10 branch, 11 load/store
//   func7_5, func7_0  func7[5] (alternate op), func7[0] (M-extension)
//   func3, rs1, rs2   instruction func3 and operands
//   op, sel           ALU operation and alternate select (combinational)
//   md_stall          hold the pipeline until the M-op completes (combinational)
//   md_busy           engine is iterating (registered)
//   md_done           one-cycle pulse, md_result valid (registered)
//   md_result         multiply/divide result (registered)
module alu_ctrl_md #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [1:0]      alu_op,
    input  logic            func7_5,
    input  logic            func7_0,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [2:0]      op,
    output logic            sel,
    output logic            md_stall,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        func3_q, func3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   a_q, a_d;       // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0]   b_q, b_d;       // divisor magnitude
    logic [XLEN:0]     rem_q, rem_d;
    logic [2*XLEN-1:0] prod_q, prod_d; // high: partial sum, low: remaining multiplier bits
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Base decode
    always_comb begin
        op  = 3'b000;
        sel = 1'b0;
        case (alu_op)
            2'b00: begin
                op  = func3;
                sel = ((func3 == 3'b000 || func3 == 3'b101) && func7_5) ||
                      func3 == 3'b010 || func3 == 3'b011;
            end
            2'b01: begin
                op  = func3;
                sel = (func3 == 3'b101 && func7_5) || func3 == 3'b010 || func3 == 3'b011;
            end
            2'b10:   sel = 1'b1;
            default: sel = 1'b0;
        endcase
    end

    logic m_op;
    assign m_op = valid_i && alu_op == 2'b00 && func7_0;

    // Accept-time operand conditioning
    logic            a_signed, b_signed, a_neg, b_neg, res_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        // MUL low half is sign-agnostic, so treating it as signed is harmless
        a_signed = (func3 == 3'b000 || func3 == 3'b001 || func3 == 3'b010) ||
                   (func3[2] && !func3[0]);
        b_signed = (func3 == 3'b000 || func3 == 3'b001) || (func3[2] && !func3[0]);
        a_neg    = a_signed && rs1[XLEN-1];
        b_neg    = b_signed && rs2[XLEN-1];
        a_mag    = a_neg ? '0 - rs1 : rs1;
        b_mag    = b_neg ? '0 - rs2 : rs2;
        // Remainder takes the dividend's sign
        res_neg  = (func3[2] && func3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = func3[2] && rs2 == '0;
        div_ovf  = func3[2] && !func3[0] && rs1 == MinNeg && rs2 == '1;
        if (div_zero) fast_res = func3[1] ? rs1 : '1;
        else          fast_res = func3[1] ? '0 : rs1;
    end

    // One iteration of each algorithm
    logic [XLEN:0]     mul_sum, div_shift, div_diff, rem_next;
    logic [2*XLEN-1:0] mul_next, prod_fin;
    logic [XLEN-1:0]   quo_next, div_raw, div_fin, calc_res;
    logic              div_borrow;

    always_comb begin
        mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? a_q : '0)};
        mul_next   = {mul_sum, prod_q[XLEN-1:1]};
        div_shift  = {rem_q[XLEN-1:0], a_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, b_q};
        div_borrow = div_diff[XLEN];
        rem_next   = div_borrow ? div_shift : div_diff;
        quo_next   = {a_q[XLEN-2:0], ~div_borrow};
        prod_fin   = neg_q ? '0 - mul_next : mul_next;
        div_raw    = func3_q[1] ? rem_next[XLEN-1:0] : quo_next;
        div_fin    = neg_q ? '0 - div_raw : div_raw;
        if (func3_q[2])             calc_res = div_fin;
        else if (func3_q == 3'b000) calc_res = prod_fin[XLEN-1:0];
        else                        calc_res = prod_fin[2*XLEN-1:XLEN];
    end

    // Next-state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        prod_d   = prod_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (m_op && !flush_i) begin
                    func3_d = func3;
                    neg_d   = res_neg;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    rem_d   = '0;
                    prod_d  = {{XLEN{1'b0}}, b_mag};
                    cnt_d   = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = StCalc;
                        busy_d  = 1'b1;
                    end
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    if (func3_q[2]) begin
                        a_d   = quo_next;
                        rem_d = rem_next;
                    end else begin
                        prod_d = mul_next;
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = calc_res;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            func3_q  <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign md_stall  = (state_q == StIdle && m_op) || state_q == StCalc;
    assign md_busy   = busy_q;
    assign md_done   = done_q;
    assign md_result = result_q;

endmodule
